vga_pixel_fetch: RTL and testbench

//  Downstream stage of the 640x480 VGA timing generator. Consumes its h_cnt/v_cnt/valid/hsync/vsync.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_pixel_fetch_if.sv | 39 +++
 rtl/vga_delay_line.sv | 32 +++
 rtl/vga_pixel_fetch.sv | 116 +++++++++++
 tb/tb_vga_pixel_fetch.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_pkg: display geometry, frame buffer constants, bank FSM encodings  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
package vga_pkg;

  localparam int HD    = 640;
  localparam int VD    = 480;
  localparam int FB_W  = 320;
  localparam int FB_H  = 240;
  localparam int PIX_W = 12;

  typedef enum logic [0:0] {
    BANK_DISPLAY = 1'b0,
    BANK_PENDING = 1'b1
  } bank_state_e;

  // Multiply by a constant as a sum of shifted copies, so no multiplier is inferred.
  function automatic logic [31:0] mul_const(input logic [31:0] x, input logic [31:0] k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_fetch_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_pixel_fetch_if: timing-in, frame buffer read and pixel-out bundle  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
interface vga_pixel_fetch_if #(
  parameter int ADDR_W = 17,
  parameter int PIX_W  = vga_pkg::PIX_W
);
  import vga_pkg::*;

  logic                        valid_in;
  logic [$clog2(HD)-1:0]       h_cnt;
  logic [$clog2(HD)-1:0]       v_cnt;
  logic                        hsync_in;
  logic                        vsync_in;
  logic                        frame_ready;
  logic [ADDR_W:0]             rd_addr;
  logic [PIX_W-1:0]            rd_data;
  logic                        rd_bank;
  logic [PIX_W-1:0]            rgb;
  logic                        hsync;
  logic                        vsync;
  logic                        de;

  // Environment side: timing generator, writer handshake and frame buffer.
  modport master (
    output valid_in, h_cnt, v_cnt, hsync_in, vsync_in, frame_ready, rd_data,
    input  rd_addr, rd_bank, rgb, hsync, vsync, de
  );

  // Pixel fetch side.
  modport slave (
    input  valid_in, h_cnt, v_cnt, hsync_in, vsync_in, frame_ready, rd_data,
    output rd_addr, rd_bank, rgb, hsync, vsync, de
  );

endinterface
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_delay_line: DEPTH-stage shift register with a fixed reset pattern  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic             pclk,
  input  wire logic             reset,
  input  wire logic [WIDTH-1:0] d_i,
  output logic      [WIDTH-1:0] q_o
);
  import vga_pkg::*;

  logic [WIDTH-1:0] tap_q [DEPTH];

  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tap_q[i] <= RESET_VAL;
    end else begin
      tap_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) tap_q[i] <= tap_q[i-1];
    end
  end

  assign q_o = tap_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_pixel_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_pixel_fetch: upscaled frame buffer fetch with bank swap at vsync   |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module vga_pixel_fetch #(
  parameter int FB_W        = vga_pkg::FB_W,
  parameter int FB_H        = vga_pkg::FB_H,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int RD_LAT      = 1,
  parameter int PIX_W       = vga_pkg::PIX_W
) (
  input wire logic         pclk,
  input wire logic         reset,
  vga_pixel_fetch_if.slave bus
);
  import vga_pkg::*;

  localparam int L     = RD_LAT + 2;
  localparam int ROW_W = $clog2(FB_H);
  localparam int COL_W = $clog2(FB_W);

  logic [ROW_W-1:0]  fb_row;
  logic [COL_W-1:0]  fb_col;
  logic [ADDR_W:0]   rd_addr_d, rd_addr_q;
  logic [PIX_W-1:0]  rgb_q;
  logic              de_q;
  logic              de_pipe;
  logic [1:0]        sync_dly;
  bank_state_e       state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic              vs_prev_q;
  logic              vs_fall;

  // Display coordinates scaled down to frame buffer coordinates, then row*FB_W+col.
  always_comb begin
    fb_row    = ROW_W'(bus.v_cnt >> SCALE_SHIFT);
    fb_col    = COL_W'(bus.h_cnt >> SCALE_SHIFT);
    rd_addr_d = {rd_bank_q, ADDR_W'(mul_const(32'(fb_row), 32'(FB_W)) + 32'(fb_col))};
  end

  assign vs_fall = vs_prev_q & ~bus.vsync_in;

  // A finished frame is queued until the next vsync fall; a pulse on that very edge
  // while already queued leaves the newer frame queued for the following vsync.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    case (state_q)
      BANK_DISPLAY: begin
        if (bus.frame_ready) begin
          if (vs_fall) rd_bank_d = ~rd_bank_q;
          else         state_d   = BANK_PENDING;
        end
      end
      BANK_PENDING: begin
        if (vs_fall) begin
          rd_bank_d = ~rd_bank_q;
          if (!bus.frame_ready) state_d = BANK_DISPLAY;
        end
      end
      default: state_d = BANK_DISPLAY;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q   <= BANK_DISPLAY;
      rd_bank_q <= 1'b0;
      vs_prev_q <= 1'b1;
      rd_addr_q <= '0;
      rgb_q     <= '0;
      de_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      vs_prev_q <= bus.vsync_in;
      rd_addr_q <= rd_addr_d;
      rgb_q     <= de_pipe ? bus.rd_data : '0;
      de_q      <= de_pipe;
    end
  end

  // Syncs take the full L stages; valid stops one short so it can gate the output register.
  vga_delay_line #(
    .WIDTH     (2),
    .DEPTH     (L),
    .RESET_VAL (2'b11)
  ) u_sync_dly (
    .pclk  (pclk),
    .reset (reset),
    .d_i   ({bus.hsync_in, bus.vsync_in}),
    .q_o   (sync_dly)
  );

  vga_delay_line #(
    .WIDTH     (1),
    .DEPTH     (L - 1),
    .RESET_VAL (1'b0)
  ) u_valid_dly (
    .pclk  (pclk),
    .reset (reset),
    .d_i   (bus.valid_in),
    .q_o   (de_pipe)
  );

  assign bus.rd_addr = rd_addr_q;
  assign bus.rd_bank = rd_bank_q;
  assign bus.rgb     = rgb_q;
  assign bus.hsync   = sync_dly[1];
  assign bus.vsync   = sync_dly[0];
  assign bus.de      = de_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_vga_pixel_fetch: randomized compressed-frame bench, RD_LAT 1 and 2  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_vga_pixel_fetch;

  localparam int AW        = 17;
  localparam int PW        = 12;
  localparam int NLINES    = 24;
  localparam int LINE_LEN  = 18;
  localparam int ACT       = 12;
  localparam int VBL       = 10;
  localparam int FRAME_LEN = NLINES * LINE_LEN + VBL;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       fr;
  } stim_t;

  logic pclk = 1'b0;
  logic reset;
  always #5 pclk = ~pclk;

  vga_pixel_fetch_if #(.ADDR_W(AW), .PIX_W(PW)) bus1 ();
  vga_pixel_fetch_if #(.ADDR_W(AW), .PIX_W(PW)) bus2 ();

  vga_pixel_fetch #(.RD_LAT(1)) u_dut1 (.pclk(pclk), .reset(reset), .bus(bus1));
  vga_pixel_fetch #(.RD_LAT(2)) u_dut2 (.pclk(pclk), .reset(reset), .bus(bus2));

  // Frame buffer models: each word holds the low 12 bits of its own address.
  logic [AW:0] mem1_q, mem2a_q, mem2b_q;
  always @(posedge pclk) begin
    mem1_q  <= bus1.rd_addr;
    mem2a_q <= bus2.rd_addr;
    mem2b_q <= mem2a_q;
  end
  assign bus1.rd_data = mem1_q[11:0];
  assign bus2.rd_data = mem2b_q[11:0];

  logic [14:0] obs1, obs2;
  assign obs1 = {bus1.rgb, bus1.de, bus1.hsync, bus1.vsync};
  assign obs2 = {bus2.rgb, bus2.de, bus2.hsync, bus2.vsync};

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_rst = 0;
  stim_t       hist [1024];
  logic        bank_m = 1'b0;
  logic        pend_m = 1'b0;
  logic        prev_vs_m = 1'b1;
  logic [14:0] exp1, exp2;
  logic [AW:0] exp_addr;

  function automatic int fb_addr(input int h, input int v);
    return (v / 2) * 320 + h / 2;
  endfunction

  // Output seen after an edge comes from the input applied lat-1 edges earlier.
  function automatic logic [14:0] expect_out(input int lat);
    int          src;
    stim_t       s;
    logic [11:0] px;
    src = cyc - (lat - 1);
    if (src <= last_rst) return {12'h000, 1'b0, 1'b1, 1'b1};
    s  = hist[src % 1024];
    px = s.valid ? 12'(fb_addr(int'(s.h), int'(s.v))) : 12'h000;
    return {px, s.valid, s.hs, s.vs};
  endfunction

  task automatic tick(input stim_t s);
    logic fall;
    reset            = s.rst;
    bus1.valid_in    = s.valid;  bus2.valid_in    = s.valid;
    bus1.h_cnt       = s.h;      bus2.h_cnt       = s.h;
    bus1.v_cnt       = s.v;      bus2.v_cnt       = s.v;
    bus1.hsync_in    = s.hs;     bus2.hsync_in    = s.hs;
    bus1.vsync_in    = s.vs;     bus2.vsync_in    = s.vs;
    bus1.frame_ready = s.fr;     bus2.frame_ready = s.fr;
    @(posedge pclk);
    #1;
    cyc++;
    hist[cyc % 1024] = s;
    if (s.rst) begin
      last_rst  = cyc;
      bank_m    = 1'b0;
      pend_m    = 1'b0;
      prev_vs_m = 1'b1;
      exp_addr  = '0;
    end else begin
      exp_addr = {bank_m, AW'(fb_addr(int'(s.h), int'(s.v)))};
      fall     = prev_vs_m && !s.vs;
      // A queued (or just-finished) frame is shown at vsync; a pulse on that edge queues the next one.
      if (fall) begin
        if (pend_m || s.fr) begin
          bank_m = ~bank_m;
          pend_m = pend_m && s.fr;
        end
      end else begin
        pend_m = pend_m || s.fr;
      end
      prev_vs_m = s.vs;
    end
    exp1 = expect_out(3);
    exp2 = expect_out(4);
  endtask

  // Compressed frame: NLINES lines at v=line*20, ACT active columns with random h, then vblank.
  function automatic stim_t frame_stim(input int idx, input int fr_a, input int fr_b,
                                       input bit fr_vs, input int rst_line, input int rst_col);
    stim_t s;
    int    line, col, b;
    s    = '0;
    s.hs = 1'b1;
    s.vs = 1'b1;
    s.h  = 10'($urandom_range(639));
    s.v  = 10'($urandom_range(479));
    if (idx < NLINES * LINE_LEN) begin
      line    = idx / LINE_LEN;
      col     = idx % LINE_LEN;
      s.v     = 10'(line * 20);
      s.valid = (col < ACT);
      s.hs    = !(col == ACT + 2 || col == ACT + 3);
      s.fr    = (col == 0) && (line == fr_a || line == fr_b);
      if (line == rst_line && col == rst_col) begin
        s.rst = 1'b1;
        s.h   = 10'd300;
      end
    end else begin
      b    = idx - NLINES * LINE_LEN;
      s.vs = !(b >= 2 && b <= 5);
      s.fr = fr_vs && (b == 2);
    end
    return s;
  endfunction

  task automatic test_reset();
    stim_t s;
    for (int i = 0; i < 5; i++) begin
      s       = frame_stim(i, -1, -1, 1'b0, -1, -1);
      s.rst   = 1'b1;
      s.valid = 1'b1;
      tick(s);
    end
    n_chk++; if ({obs1, obs2} !== {15'h0003, 15'h0003}) $display("FAIL reset_outputs got=%h/%h exp=0003/0003", obs1, obs2); else n_pass++;
    n_chk++; if ({bus1.rd_addr, bus1.rd_bank} !== 19'h0) $display("FAIL reset_addr_bank1 got=%h/%b exp=0/0", bus1.rd_addr, bus1.rd_bank); else n_pass++;
    n_chk++; if ({bus2.rd_addr, bus2.rd_bank} !== 19'h0) $display("FAIL reset_addr_bank2 got=%h/%b exp=0/0", bus2.rd_addr, bus2.rd_bank); else n_pass++;
  endtask

  task automatic test_addr();
    int hv [3][3] = '{'{0, 0, 0}, '{639, 479, 76799}, '{2, 3, 321}};
    stim_t s;
    for (int i = 0; i < 3; i++) begin
      s       = '0;
      s.valid = 1'b1;
      s.hs    = 1'b1;
      s.vs    = 1'b1;
      s.h     = 10'(hv[i][0]);
      s.v     = 10'(hv[i][1]);
      tick(s);
      n_chk++; if (bus1.rd_addr !== 18'(hv[i][2])) $display("FAIL addr1 h=%0d v=%0d got=%0d exp=%0d", hv[i][0], hv[i][1], bus1.rd_addr, hv[i][2]); else n_pass++;
      n_chk++; if (bus2.rd_addr !== 18'(hv[i][2])) $display("FAIL addr2 h=%0d v=%0d got=%0d exp=%0d", hv[i][0], hv[i][1], bus2.rd_addr, hv[i][2]); else n_pass++;
    end
  endtask

  task automatic test_stream();
    int   toggles = 0;
    logic prev_b;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        prev_b = bus1.rd_bank;
        tick(frame_stim(i, -1, -1, 1'b0, -1, -1));
        if (bus1.rd_bank !== prev_b) toggles++;
        n_chk++; if ({obs1, obs2} !== {exp1, exp2}) $display("FAIL stream_pixel cyc=%0d got=%h/%h exp=%h/%h", cyc, obs1, obs2, exp1, exp2); else n_pass++;
        n_chk++; if ({bus1.rd_addr, bus1.rd_bank} !== {exp_addr, bank_m}) $display("FAIL stream_addr1 cyc=%0d got=%h/%b exp=%h/%b", cyc, bus1.rd_addr, bus1.rd_bank, exp_addr, bank_m); else n_pass++;
        n_chk++; if ({bus2.rd_addr, bus2.rd_bank} !== {exp_addr, bank_m}) $display("FAIL stream_addr2 cyc=%0d got=%h/%b exp=%h/%b", cyc, bus2.rd_addr, bus2.rd_bank, exp_addr, bank_m); else n_pass++;
      end
    end
    n_chk++; if (toggles !== 0) $display("FAIL stream_no_swap got=%0d toggles exp=0", toggles); else n_pass++;
  endtask

  task automatic test_swap();
    int   toggles = 0;
    logic prev_b;
    for (int i = 0; i < FRAME_LEN; i++) begin
      prev_b = bus1.rd_bank;
      tick(frame_stim(i, 5, 10, 1'b0, -1, -1));
      if (bus1.rd_bank !== prev_b) toggles++;
      n_chk++; if ({obs1, obs2} !== {exp1, exp2}) $display("FAIL swap_pixel cyc=%0d got=%h/%h exp=%h/%h", cyc, obs1, obs2, exp1, exp2); else n_pass++;
      n_chk++; if ({bus1.rd_addr, bus1.rd_bank} !== {exp_addr, bank_m}) $display("FAIL swap_addr1 cyc=%0d got=%h/%b exp=%h/%b", cyc, bus1.rd_addr, bus1.rd_bank, exp_addr, bank_m); else n_pass++;
      n_chk++; if ({bus2.rd_addr, bus2.rd_bank} !== {exp_addr, bank_m}) $display("FAIL swap_addr2 cyc=%0d got=%h/%b exp=%h/%b", cyc, bus2.rd_addr, bus2.rd_bank, exp_addr, bank_m); else n_pass++;
    end
    n_chk++; if (toggles !== 1) $display("FAIL swap_once got=%0d toggles exp=1", toggles); else n_pass++;
  endtask

  task automatic test_coincident();
    int   toggles;
    logic prev_b;
    for (int f = 0; f < 2; f++) begin
      toggles = 0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        prev_b = bus1.rd_bank;
        tick(f == 0 ? frame_stim(i, 5, -1, 1'b1, -1, -1) : frame_stim(i, -1, -1, 1'b0, -1, -1));
        if (bus1.rd_bank !== prev_b) toggles++;
        n_chk++; if ({obs1, obs2} !== {exp1, exp2}) $display("FAIL coinc_pixel cyc=%0d got=%h/%h exp=%h/%h", cyc, obs1, obs2, exp1, exp2); else n_pass++;
        n_chk++; if ({bus1.rd_addr, bus1.rd_bank} !== {exp_addr, bank_m}) $display("FAIL coinc_addr1 cyc=%0d got=%h/%b exp=%h/%b", cyc, bus1.rd_addr, bus1.rd_bank, exp_addr, bank_m); else n_pass++;
        n_chk++; if ({bus2.rd_addr, bus2.rd_bank} !== {exp_addr, bank_m}) $display("FAIL coinc_addr2 cyc=%0d got=%h/%b exp=%h/%b", cyc, bus2.rd_addr, bus2.rd_bank, exp_addr, bank_m); else n_pass++;
      end
      n_chk++; if (toggles !== 1) $display("FAIL coinc_toggle frame=%0d got=%0d exp=1", f, toggles); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int   toggles;
    logic prev_b;
    for (int f = 0; f < 2; f++) begin
      toggles = 0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        prev_b = bus1.rd_bank;
        tick(f == 0 ? frame_stim(i, 5, -1, 1'b0, 12, 5) : frame_stim(i, -1, -1, 1'b0, -1, -1));
        if (bus1.rd_bank !== prev_b) toggles++;
        n_chk++; if ({obs1, obs2} !== {exp1, exp2}) $display("FAIL rstmid_pixel cyc=%0d got=%h/%h exp=%h/%h", cyc, obs1, obs2, exp1, exp2); else n_pass++;
        n_chk++; if ({bus1.rd_addr, bus1.rd_bank} !== {exp_addr, bank_m}) $display("FAIL rstmid_addr1 cyc=%0d got=%h/%b exp=%h/%b", cyc, bus1.rd_addr, bus1.rd_bank, exp_addr, bank_m); else n_pass++;
        n_chk++; if ({bus2.rd_addr, bus2.rd_bank} !== {exp_addr, bank_m}) $display("FAIL rstmid_addr2 cyc=%0d got=%h/%b exp=%h/%b", cyc, bus2.rd_addr, bus2.rd_bank, exp_addr, bank_m); else n_pass++;
      end
      n_chk++; if (bus1.rd_bank !== 1'b0) $display("FAIL rstmid_bank frame=%0d got=%b exp=0", f, bus1.rd_bank); else n_pass++;
    end
    n_chk++; if (toggles !== 0) $display("FAIL rstmid_pending_cleared got=%0d toggles exp=0", toggles); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addr();
    test_stream();
    test_swap();
    test_coincident();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
